// File: rtl/seq_chunk_adder_if.sv
// seq_chunk_adder_if -- request/response bundle for seq_chunk_adder.
//   start, sub, number1, number2 : request, driven by the master
//   busy, done, result, carry_out, overflow : status/result, driven by the adder
interface seq_chunk_adder_if #(
  parameter int N = 8
);
  logic         start;
  logic         sub;
  logic [N-1:0] number1;
  logic [N-1:0] number2;
  logic         busy;
  logic         done;
  logic [N-1:0] result;
  logic         carry_out;
  logic         overflow;

  modport master (
    output start, sub, number1, number2,
    input  busy, done, result, carry_out, overflow
  );

  modport slave (
    input  start, sub, number1, number2,
    output busy, done, result, carry_out, overflow
  );
endinterface

// File: rtl/seq_chunk_adder.sv
// seq_chunk_adder -- multi-cycle N-bit add/subtract, CHUNK bits per clock,
// carry rippled through a register between chunks.
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : seq_chunk_adder_if.slave (start/sub/number1/number2 in;
//           busy/done/result/carry_out/overflow out)
// Latency: done pulses N/CHUNK cycles after the accepting start edge.
module seq_chunk_adder #(
  parameter int N     = 8,
  parameter int CHUNK = 4
) (
  input logic               clk,
  input logic               rst_n,
  seq_chunk_adder_if.slave  bus
);
  localparam int NCH = N / CHUNK;
  localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [IW-1:0] LAST = IW'(NCH - 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BUSY = 1'b1;

  if (N % CHUNK != 0) begin : g_bad_chunk
    $error("seq_chunk_adder: N must be a multiple of CHUNK");
  end

  logic [0:0]    r_state;
  logic [N-1:0]  r_a;
  logic [N-1:0]  r_b;      // already inverted for subtract
  logic          r_carry;
  logic [IW-1:0] r_idx;
  logic [N-1:0]  r_part;   // partial result, never visible on the outputs
  logic          r_busy;
  logic          r_done;
  logic [N-1:0]  r_result;
  logic          r_co;
  logic          r_ov;

  logic [CHUNK-1:0] w_a_sl;
  logic [CHUNK-1:0] w_b_sl;
  logic [CHUNK:0]   w_sum;
  logic [N-1:0]     w_part_nxt;

  always_comb begin
    w_a_sl     = r_a[r_idx*CHUNK +: CHUNK];
    w_b_sl     = r_b[r_idx*CHUNK +: CHUNK];
    w_sum      = {1'b0, w_a_sl} + {1'b0, w_b_sl} + (CHUNK+1)'(r_carry);
    w_part_nxt = r_part;
    w_part_nxt[r_idx*CHUNK +: CHUNK] = w_sum[CHUNK-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_carry  <= 1'b0;
      r_idx    <= '0;
      r_part   <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
      r_co     <= 1'b0;
      r_ov     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_a     <= bus.number1;
            // subtract as A + ~B + 1: the +1 rides in on the initial carry
            r_b     <= bus.sub ? ~bus.number2 : bus.number2;
            r_carry <= bus.sub;
            r_idx   <= '0;
            r_part  <= '0;
            r_busy  <= 1'b1;
            r_state <= S_BUSY;
          end
        end
        S_BUSY: begin
          r_part  <= w_part_nxt;
          r_carry <= w_sum[CHUNK];
          if (r_idx == LAST) begin
            r_result <= w_part_nxt;
            r_co     <= w_sum[CHUNK];
            r_ov     <= (r_a[N-1] == r_b[N-1]) && (w_part_nxt[N-1] != r_a[N-1]);
            r_done   <= 1'b1;
            r_busy   <= 1'b0;
            r_idx    <= '0;
            r_state  <= S_IDLE;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.result    = r_result;
  assign bus.carry_out = r_co;
  assign bus.overflow  = r_ov;
endmodule

// File: tb/tb_seq_chunk_adder.sv
module tb_seq_chunk_adder;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // main DUT: N=8, CHUNK=4
  seq_chunk_adder_if #(.N(8))  b84 ();
  // sweep DUTs
  seq_chunk_adder_if #(.N(8))  b81 ();
  seq_chunk_adder_if #(.N(8))  b82 ();
  seq_chunk_adder_if #(.N(8))  b88 ();
  seq_chunk_adder_if #(.N(16)) b164 ();

  seq_chunk_adder #(.N(8),  .CHUNK(4)) u84  (.clk(clk), .rst_n(rst_n), .bus(b84));
  seq_chunk_adder #(.N(8),  .CHUNK(1)) u81  (.clk(clk), .rst_n(rst_n), .bus(b81));
  seq_chunk_adder #(.N(8),  .CHUNK(2)) u82  (.clk(clk), .rst_n(rst_n), .bus(b82));
  seq_chunk_adder #(.N(8),  .CHUNK(8)) u88  (.clk(clk), .rst_n(rst_n), .bus(b88));
  seq_chunk_adder #(.N(16), .CHUNK(4)) u164 (.clk(clk), .rst_n(rst_n), .bus(b164));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // reference: whole-width arithmetic, overflow from signed range
  task automatic model(input int n, input logic [15:0] a, input logic [15:0] b, input logic s,
                       output logic [15:0] r, output logic c, output logic v);
    int unsigned mask;
    int sa, sb, sv, lo, hi;
    mask = (32'd1 << n) - 1;
    sa = (a[n-1]) ? int'(a) - (1 << n) : int'(a);
    sb = (b[n-1]) ? int'(b) - (1 << n) : int'(b);
    sv = s ? sa - sb : sa + sb;
    lo = -(1 << (n-1));
    hi = (1 << (n-1)) - 1;
    v  = (sv < lo) || (sv > hi);
    if (s) begin
      r = 16'((int'(a) - int'(b)) & mask);
      c = (a >= b);
    end else begin
      r = 16'((int'(a) + int'(b)) & mask);
      c = ((int'(a) + int'(b)) >> n) & 1;
    end
  endtask

  // one full operation on the 8/4 DUT, start on the next edge
  task automatic op(input string tag, input logic [7:0] a, input logic [7:0] b, input logic s,
                    input logic [7:0] er, input logic ec, input logic ev);
    logic [7:0] prev;
    prev = b84.result;
    b84.number1 = a; b84.number2 = b; b84.sub = s; b84.start = 1'b1;
    tick();
    b84.start = 1'b0;
    chk({tag, "_busy0"}, b84.busy, 1'b1);
    chk({tag, "_hold"}, b84.result, prev);
    tick();
    chk({tag, "_done_early"}, b84.done, 1'b0);
    tick();
    chk({tag, "_done"}, b84.done, 1'b1);
    chk({tag, "_busy_end"}, b84.busy, 1'b0);
    chk({tag, "_res"}, b84.result, er);
    chk({tag, "_co"}, b84.carry_out, ec);
    chk({tag, "_ov"}, b84.overflow, ev);
  endtask

  function automatic void drive_all(logic st, logic s, logic [15:0] a, logic [15:0] b);
    b81.start = st; b82.start = st; b88.start = st; b164.start = st;
    b81.sub = s; b82.sub = s; b88.sub = s; b164.sub = s;
    b81.number1 = a[7:0]; b82.number1 = a[7:0]; b88.number1 = a[7:0]; b164.number1 = a;
    b81.number2 = b[7:0]; b82.number2 = b[7:0]; b88.number2 = b[7:0]; b164.number2 = b;
  endfunction

  initial begin
    logic [15:0] a, b, er;
    logic s, ec, ev;
    int lat [4];
    logic [15:0] res [4];
    logic co [4], ov [4];
    int nch [4] = '{8, 4, 1, 4};
    int nw  [4] = '{8, 8, 8, 16};

    rst_n = 1'b0;
    b84.start = 1'b0; b84.sub = 1'b0; b84.number1 = '0; b84.number2 = '0;
    drive_all(1'b0, 1'b0, 16'h0, 16'h0);
    tick(); tick();
    chk("rst_busy", b84.busy, 1'b0);
    chk("rst_done", b84.done, 1'b0);
    chk("rst_res", b84.result, 8'h00);
    chk("rst_co", b84.carry_out, 1'b0);
    chk("rst_ov", b84.overflow, 1'b0);
    rst_n = 1'b1;
    tick();

    op("a90_18",  8'd90,  8'd18,  1'b0, 8'h6C, 1'b0, 1'b0);
    op("a96_53",  8'd96,  8'd53,  1'b0, 8'h95, 1'b0, 1'b1);
    op("a200_100",8'd200, 8'd100, 1'b0, 8'h2C, 1'b1, 1'b0);
    op("s21_52",  8'd21,  8'd52,  1'b1, 8'hE1, 1'b0, 1'b0);
    op("s52_21",  8'd52,  8'd21,  1'b1, 8'h1F, 1'b1, 1'b0);
    tick();
    chk("done_clear", b84.done, 1'b0);

    // inputs and start during BUSY are ignored
    b84.number1 = 8'd73; b84.number2 = 8'd86; b84.sub = 1'b0; b84.start = 1'b1;
    tick();
    b84.number1 = 8'hFF;  // start still high during BUSY
    tick();
    b84.start = 1'b0;
    tick();
    chk("ign_done", b84.done, 1'b1);
    chk("ign_res", b84.result, 8'h9F);
    chk("ign_ov", b84.overflow, 1'b1);
    // start in the done cycle
    b84.number1 = 8'd71; b84.number2 = 8'd71; b84.start = 1'b1;
    tick();
    b84.start = 1'b0;
    chk("b2b_busy", b84.busy, 1'b1);
    chk("b2b_done_clr", b84.done, 1'b0);
    chk("b2b_hold", b84.result, 8'h9F);
    tick();
    tick();
    chk("b2b_done", b84.done, 1'b1);
    chk("b2b_res", b84.result, 8'h8E);
    chk("b2b_ov", b84.overflow, 1'b1);
    chk("b2b_co", b84.carry_out, 1'b0);

    // reset mid-operation
    b84.number1 = 8'd55; b84.number2 = 8'd85; b84.start = 1'b1;
    tick();
    b84.start = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("abort_busy", b84.busy, 1'b0);
    chk("abort_done", b84.done, 1'b0);
    chk("abort_res", b84.result, 8'h00);
    chk("abort_co", b84.carry_out, 1'b0);
    chk("abort_ov", b84.overflow, 1'b0);
    tick();
    chk("abort_nodone1", b84.done, 1'b0);
    tick();
    chk("abort_nodone2", b84.done, 1'b0);
    op("post_rst", 8'd3, 8'd4, 1'b0, 8'h07, 1'b0, 1'b0);

    // parameter sweep, directed plus random operands
    for (int it = 0; it < 8; it++) begin
      case (it)
        0: begin a = 16'h00FF; b = 16'h0001; s = 1'b0; end
        1: begin a = 16'h0000; b = 16'h0001; s = 1'b1; end
        2: begin a = 16'h7F7F; b = 16'h0101; s = 1'b0; end
        3: begin a = 16'h8080; b = 16'h0101; s = 1'b1; end
        default: begin a = 16'($urandom); b = 16'($urandom); s = 1'($urandom); end
      endcase
      drive_all(1'b1, s, a, b);
      for (int d = 0; d < 4; d++) lat[d] = 0;
      tick();
      drive_all(1'b0, s, a, b);
      for (int k = 1; k <= 20; k++) begin
        tick();
        if (b81.done && lat[0] == 0) begin lat[0] = k; res[0] = 16'(b81.result); co[0] = b81.carry_out; ov[0] = b81.overflow; end
        if (b82.done && lat[1] == 0) begin lat[1] = k; res[1] = 16'(b82.result); co[1] = b82.carry_out; ov[1] = b82.overflow; end
        if (b88.done && lat[2] == 0) begin lat[2] = k; res[2] = 16'(b88.result); co[2] = b88.carry_out; ov[2] = b88.overflow; end
        if (b164.done && lat[3] == 0) begin lat[3] = k; res[3] = b164.result; co[3] = b164.carry_out; ov[3] = b164.overflow; end
      end
      for (int d = 0; d < 4; d++) begin
        model(nw[d], (nw[d] == 8) ? {8'h00, a[7:0]} : a, (nw[d] == 8) ? {8'h00, b[7:0]} : b, s, er, ec, ev);
        chk($sformatf("sw%0d_d%0d_lat", it, d), lat[d], nch[d]);
        if (lat[d] != 0) begin
          chk($sformatf("sw%0d_d%0d_res", it, d), res[d], er);
          chk($sformatf("sw%0d_d%0d_co", it, d), co[d], ec);
          chk($sformatf("sw%0d_d%0d_ov", it, d), ov[d], ev);
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
